vec_elem_reader: RTL and testbench

//  Read-side companion of the vector register file: walks the active elements of one vector

---
 rtl/vec_elem_reader.sv | 159 +++++++++++++++
 tb/tb_vec_elem_reader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_elem_reader.sv
// rtl/vec_elem_reader.sv - streams the active elements of a vector register group (option: VEC_READ_SIGN_EXT_EN)
`ifndef VLEN
`define VLEN 128
`endif

module vec_elem_reader #(
    parameter int VLEN = `VLEN,
    parameter int NREG = 32
) (
    input  logic                 SYS_clk,
    input  logic                 SYS_reset,
    input  logic                 start,
    input  logic [4:0]           vs_idx,
    input  logic [VLEN*NREG-1:0] v_regs,
    input  logic [31:0]          vl,
    input  logic [31:0]          vstart,
    input  logic                 vill,
    input  logic [2:0]           vsew,
    input  logic [2:0]           vlmul,
    output logic                 elem_valid,
    input  logic                 elem_ready,
    output logic [31:0]          elem_data,
    output logic [31:0]          elem_index,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);
    localparam int LOG_VLEN = $clog2(VLEN);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_STREAM} state_t;

    state_t      state_q, state_d;
    logic [4:0]  vs_q, vs_d;
    logic [31:0] vl_q, vl_d;
    logic [31:0] idx_q, idx_d;
    logic        vill_q, vill_d;
    logic [2:0]  sew_q, sew_d;
    logic [2:0]  lmul_q, lmul_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic [4:0]      lmul_mask;
    logic [31:0]     vlmax;
    logic            illegal;
    logic [31:0]     bit_off;
    logic [4:0]      reg_sel;
    logic [VLEN-1:0] reg_word;
    logic [31:0]     raw;

    // Legality of the captured request: vtype, group alignment and vl bound
    always_comb begin
        lmul_mask = (5'd1 << lmul_q[1:0]) - 5'd1;
        vlmax     = (32'(VLEN) << lmul_q[1:0]) >> (3 + sew_q[1:0]);
        illegal   = vill_q || (sew_q > 3'd2) || lmul_q[2] ||
                    ((vs_q & lmul_mask) != 5'd0) || (vl_q > vlmax);
    end

    // Element idx lives at bit idx*SEW of the group; pick its register, then its field
    always_comb begin
        bit_off   = idx_q << (3 + sew_q[1:0]);
        reg_sel   = vs_q + 5'(bit_off >> LOG_VLEN);
        reg_word  = v_regs[int'(reg_sel)*VLEN +: VLEN];
        raw       = 32'(reg_word >> bit_off[LOG_VLEN-1:0]);
        elem_data = 32'd0;
        if (state_q == S_STREAM) begin
            case (sew_q)
`ifdef VEC_READ_SIGN_EXT_EN
                3'd0:    elem_data = {{24{raw[7]}}, raw[7:0]};
                3'd1:    elem_data = {{16{raw[15]}}, raw[15:0]};
`else
                3'd0:    elem_data = {24'd0, raw[7:0]};
                3'd1:    elem_data = {16'd0, raw[15:0]};
`endif
                default: elem_data = raw;
            endcase
        end
    end

    // Request sequencing: capture, one-cycle check, then one element per accepted beat
    always_comb begin
        state_d = state_q;
        vs_d    = vs_q;
        vl_d    = vl_q;
        idx_d   = idx_q;
        vill_d  = vill_q;
        sew_d   = sew_q;
        lmul_d  = lmul_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    vs_d    = vs_idx;
                    vl_d    = vl;
                    idx_d   = vstart;
                    vill_d  = vill;
                    sew_d   = vsew;
                    lmul_d  = vlmul;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (illegal) begin
                    done_d  = 1'b1;
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else if (idx_q >= vl_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (elem_ready) begin
                    if (idx_q == vl_q - 32'd1) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 32'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and captured request registers
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            state_q <= S_IDLE;
            vs_q    <= 5'd0;
            vl_q    <= 32'd0;
            idx_q   <= 32'd0;
            vill_q  <= 1'b0;
            sew_q   <= 3'd0;
            lmul_q  <= 3'd0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            vs_q    <= vs_d;
            vl_q    <= vl_d;
            idx_q   <= idx_d;
            vill_q  <= vill_d;
            sew_q   <= sew_d;
            lmul_q  <= lmul_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign elem_valid = (state_q == S_STREAM);
    assign elem_index = idx_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_vec_elem_reader.sv
// tb/tb_vec_elem_reader.sv - self-checking bench for vec_elem_reader
module tb_vec_elem_reader;
    localparam int VLEN = 128;
    localparam int NREG = 32;
`ifdef VEC_READ_SIGN_EXT_EN
    localparam logic [31:0] EXP80 = 32'hFFFFFF80;
`else
    localparam logic [31:0] EXP80 = 32'h00000080;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [4:0]           vs_idx;
    logic [VLEN*NREG-1:0] v_regs;
    logic [31:0]          vl;
    logic [31:0]          vstart;
    logic                 vill;
    logic [2:0]           vsew;
    logic [2:0]           vlmul;
    logic                 elem_valid;
    logic                 elem_ready;
    logic [31:0]          elem_data;
    logic [31:0]          elem_index;
    logic                 busy;
    logic                 done;
    logic                 error;

    always #5 clk = ~clk;

    vec_elem_reader #(.VLEN(VLEN), .NREG(NREG)) dut (
        .SYS_clk(clk), .SYS_reset(rst), .start(start), .vs_idx(vs_idx), .v_regs(v_regs),
        .vl(vl), .vstart(vstart), .vill(vill), .vsew(vsew), .vlmul(vlmul),
        .elem_valid(elem_valid), .elem_ready(elem_ready), .elem_data(elem_data),
        .elem_index(elem_index), .busy(busy), .done(done), .error(error)
    );

    typedef struct {
        logic [4:0]  vs;
        logic [31:0] vl;
        logic [31:0] vstart;
        logic        vill;
        logic [2:0]  sew;
        logic [2:0]  lmul;
        int          mode;
        bit          poke;
        bit          err;
        bit          chk_en;
        logic [31:0] chk_idx;
        logic [31:0] chk_val;
    } req_t;

    typedef struct {
        logic [31:0] idx;
        logic [31:0] data;
    } beat_t;

    req_t  tbl[$];
    beat_t exp_q[$];
    int    errs = 0;
    int    checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic add(input logic [4:0] vs_i, input logic [31:0] vl_i, input logic [31:0] vst_i,
                       input logic vill_i, input logic [2:0] sew_i, input logic [2:0] lmul_i,
                       input int mode_i, input bit poke_i, input bit err_i, input bit ce_i,
                       input logic [31:0] ci_i, input logic [31:0] cv_i);
        req_t r;
        r.vs = vs_i; r.vl = vl_i; r.vstart = vst_i; r.vill = vill_i; r.sew = sew_i;
        r.lmul = lmul_i; r.mode = mode_i; r.poke = poke_i; r.err = err_i;
        r.chk_en = ce_i; r.chk_idx = ci_i; r.chk_val = cv_i;
        tbl.push_back(r);
    endtask

    // Byte-addressed view of the register file: element i of group vs at byte vs*16 + i*bytes
    function automatic logic [31:0] model(input logic [4:0] vs, input logic [31:0] i, input logic [2:0] sew);
        int nb = 1 << sew;
        int base = int'(vs) * (VLEN / 8) + int'(i) * nb;
        logic [31:0] v = 32'd0;
        for (int b = 0; b < nb; b++) v[b*8 +: 8] = v_regs[(base + b)*8 +: 8];
`ifdef VEC_READ_SIGN_EXT_EN
        if (nb == 1) v = {{24{v[7]}}, v[7:0]};
        else if (nb == 2) v = {{16{v[15]}}, v[15:0]};
`endif
        return v;
    endfunction

    task automatic run_req(input req_t r);
        int nbeats, seen, k;
        bit got_done, stalled;
        logic [31:0] pd, pi;
        beat_t e;
        nbeats = (r.err || r.vstart >= r.vl) ? 0 : int'(r.vl - r.vstart);
        for (int i = 0; i < nbeats; i++) begin
            e.idx  = r.vstart + 32'(i);
            e.data = model(r.vs, e.idx, r.sew);
            exp_q.push_back(e);
        end
        vs_idx = r.vs; vl = r.vl; vstart = r.vstart; vill = r.vill; vsew = r.sew; vlmul = r.lmul;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 0; got_done = 1'b0; stalled = 1'b0; k = 0; pd = '0; pi = '0;
        while (!got_done && k < 400) begin
            elem_ready = (r.mode == 0) ? 1'b1 : (k % 3 == 1);
            if (r.poke && k == 3) begin
                start = 1'b1; vs_idx = 5'd0; vl = 32'd1; vstart = 32'd0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (k == 0) chk("busy_in_check", busy, 1);
            if (stalled) begin
                chk("hold_valid", elem_valid, 1);
                chk("hold_data", elem_data, pd);
                chk("hold_index", elem_index, pi);
            end
            if (elem_valid && elem_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errs++;
                    $display("FAIL extra_beat: index %0d not expected", elem_index);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_index", elem_index, e.idx);
                    chk("beat_data", elem_data, e.data);
                    if (r.chk_en && e.idx == r.chk_idx) chk("spot_data", elem_data, r.chk_val);
                end
                seen++;
            end
            stalled = elem_valid && !elem_ready;
            pd = elem_data;
            pi = elem_index;
            if (done) begin
                got_done = 1'b1;
                chk("error_flag", error, r.err);
                chk("beats", seen, nbeats);
                if (r.mode == 0) chk("done_latency", k, nbeats + 1);
            end else if (error) begin
                chk("error_without_done", error, 0);
            end
            if (!got_done) begin
                @(posedge clk); #1;
                k++;
            end
        end
        start = 1'b0;
        if (!got_done) chk("done_timeout", got_done, 1);
        chk("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int seen, k;
        rst = 1'b1; start = 1'b0; elem_ready = 1'b0; vs_idx = '0; vl = '0; vstart = '0;
        vill = 1'b0; vsew = '0; vlmul = '0;
        for (int w = 0; w < VLEN*NREG/32; w++) v_regs[w*32 +: 32] = $urandom;
        for (int b = 0; b < 16; b++) v_regs[2*VLEN + b*8 +: 8] = 8'(b);
        v_regs[5*VLEN +: 32] = 32'hDEADBEEF;
        v_regs[7*VLEN +: 8]  = 8'h80;

        //  vs  vl  vst vill sew lmul mode poke err chk idx val
        add(2,  16, 0,  0,   0,  0,   0,   0,   0,  1,  15, 32'h0F);
        add(4,  8,  3,  0,   2,  1,   0,   0,   0,  1,  4,  32'hDEADBEEF);
        add(2,  16, 0,  0,   0,  0,   1,   0,   0,  1,  0,  32'h00);
        add(3,  16, 0,  0,   0,  1,   0,   0,   1,  0,  0,  0);
        add(2,  16, 0,  1,   0,  0,   0,   0,   1,  0,  0,  0);
        add(2,  8,  0,  0,   3,  0,   0,   0,   1,  0,  0,  0);
        add(2,  17, 0,  0,   0,  0,   0,   0,   1,  0,  0,  0);
        add(2,  5,  5,  0,   0,  0,   0,   0,   0,  0,  0,  0);
        add(7,  1,  0,  0,   0,  0,   0,   0,   0,  1,  0,  EXP80);
        add(8,  64, 60, 0,   1,  3,   1,   1,   0,  0,  0,  0);
        add(12, 16, 0,  0,   2,  2,   0,   0,   0,  0,  0,  0);
        add(2,  4,  0,  0,   0,  4,   0,   0,   1,  0,  0,  0);
        add(0,  0,  0,  0,   0,  0,   0,   0,   0,  0,  0,  0);
        add(16, 65, 0,  0,   1,  3,   0,   0,   1,  0,  0,  0);
        add(4,  32, 0,  0,   0,  1,   1,   0,   0,  0,  0,  0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", elem_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_busy", busy, 0);
        chk("rst_index", elem_index, 0);
        chk("rst_data", elem_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int t = 0; t < tbl.size(); t++) begin
            run_req(tbl[t]);
            @(posedge clk); #1;
            @(negedge clk);
            chk("done_one_cycle", done, 0);
            chk("idle_after_done", busy, 0);
        end

        // start presented in the done cycle is taken immediately
        run_req(tbl[0]);
        vs_idx = 5'd2; vl = 32'd5; vstart = 32'd5; vill = 1'b0; vsew = 3'd0; vlmul = 3'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("b2b_busy", busy, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b_done", done, 1);
        chk("b2b_error", error, 0);

        // reset mid-stream after three beats
        @(posedge clk); #1;
        vs_idx = 5'd2; vl = 32'd16; vstart = 32'd0; elem_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 0; k = 0;
        while (seen < 3 && k < 20) begin
            @(negedge clk);
            if (elem_valid) seen++;
            k++;
        end
        chk("rst_mid_beats", seen, 3);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_valid", elem_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_mid_no_done", done, 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
